// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - bus initiator copying a byte block within the data memory
module mem_copy_engine #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MEM_SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] count,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    // One extra bit so src+len cannot wrap before it is compared to the memory size.
    localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_SIZE);
    localparam logic [ADDR_W-1:0] ONE       = 1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] src_q, dst_q, len_q, idx_q, count_q;
    logic [DATA_W-1:0] data_q;
    logic              error_q;

    logic [ADDR_W:0]   src_end, dst_end;
    logic              range_bad;
    logic              len_zero;
    logic [ADDR_W-1:0] idx_inc;

    assign src_end   = {1'b0, src_q} + {1'b0, len_q};
    assign dst_end   = {1'b0, dst_q} + {1'b0, len_q};
    assign range_bad = (src_end > MEM_LIMIT) || (dst_end > MEM_LIMIT);
    assign len_zero  = (len_q == '0);
    assign idx_inc   = idx_q + ONE;

    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign error          = error_q;
    assign count          = count_q;
    assign mem_write_data = data_q;

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus strobes; read and write are decoded from distinct states so never overlap.
    always_comb begin
        state_next  = state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (len_zero || range_bad) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                mem_read    = 1'b1;
                mem_address = src_q + idx_q;
                state_next  = S_WRITE;
            end
            S_WRITE: begin
                mem_write   = 1'b1;
                mem_address = dst_q + idx_q;
                if (idx_inc == len_q) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_READ;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Job registers: latch arguments on an accepted start, step the index per written byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        len_q   <= length;
                        idx_q   <= '0;
                        count_q <= '0;
                        error_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    idx_q <= '0;
                    if (!len_zero && range_bad) begin
                        error_q <= 1'b1;
                    end
                end
                S_READ: begin
                    data_q <= mem_read_data;
                end
                S_WRITE: begin
                    count_q <= idx_inc;
                    idx_q   <= idx_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - directed table-driven bench for mem_copy_engine
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr, dst_addr, length;
    logic       busy, done, error;
    logic [7:0] count;
    logic       mem_read, mem_write;
    logic [7:0] mem_address, mem_write_data, mem_read_data;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .MEM_SIZE(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .length(length),
        .busy(busy),
        .done(done),
        .error(error),
        .count(count),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Memory model: combinational read, synchronous write, image load on request.
    logic [7:0] mem [0:31];
    logic       load_req = 1'b0;
    logic       load_sel = 1'b0;

    assign mem_read_data = mem_read ? mem[mem_address[4:0]] : 8'h00;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 32; i++) begin
                if (i < 16) mem[i] <= 8'(i);
                else if (load_sel && i < 20) mem[i] <= 8'hAA;
                else mem[i] <= 8'h00;
            end
        end else if (mem_write) begin
            mem[mem_address[4:0]] <= mem_write_data;
        end
    end

    // Bus protocol monitor: strobe overlap, out-of-range address, read/write alternation.
    int  rd_total = 0, wr_total = 0, bad_total = 0;
    bit  last_was_read = 1'b0;
    always @(negedge clk) begin
        if (mem_read && mem_write) bad_total++;
        if ((mem_read || mem_write) && mem_address >= 8'd32) bad_total++;
        if (mem_read) begin
            rd_total++;
            if (last_was_read) bad_total++;
            last_was_read = 1'b1;
        end
        if (mem_write) begin
            wr_total++;
            if (!last_was_read) bad_total++;
            last_was_read = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_mem [0:31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_image(input logic sel);
        @(negedge clk);
        load_sel = sel;
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) exp_mem[i] = 8'(i);
            else if (sel && i < 20) exp_mem[i] = 8'hAA;
            else exp_mem[i] = 8'h00;
        end
    endtask

    task automatic compare_mem(input string name);
        int mm;
        mm = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) mm++;
        check(name, mm, 0);
    endtask

    // Drives one start pulse and counts cycles (start cycle = 0) until done is seen.
    task automatic run_job(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           output int cyc, output bit seen);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = l;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        seen = done;
    endtask

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        logic       exp_err;
        logic [7:0] exp_count;
        int         exp_cycles;
        bit         has_last;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int  cyc;
        bit  seen;
        int  rd0, wr0, bad0, dones;

        vecs[0] = '{8'd0,  8'd20, 8'd4,  1'b0, 8'd4,  10, 1'b1, 8'd3};
        vecs[1] = '{8'd5,  8'd6,  8'd0,  1'b0, 8'd0,  2,  1'b0, 8'd0};
        vecs[2] = '{8'd30, 8'd0,  8'd3,  1'b1, 8'd0,  2,  1'b0, 8'd0};
        vecs[3] = '{8'd2,  8'd3,  8'd3,  1'b0, 8'd3,  8,  1'b1, 8'd2};
        vecs[4] = '{8'd20, 8'd29, 8'd3,  1'b0, 8'd3,  8,  1'b1, 8'd2};
        vecs[5] = '{8'd0,  8'd30, 8'd3,  1'b1, 8'd0,  2,  1'b0, 8'd0};
        vecs[6] = '{8'd0,  8'd0,  8'd32, 1'b0, 8'd32, 66, 1'b1, 8'd2};
        vecs[7] = '{8'd31, 8'd0,  8'd1,  1'b0, 8'd1,  4,  1'b1, 8'd2};

        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 8'd0;
        dst_addr = 8'd0;
        length   = 8'd0;
        load_image(1'b0);
        #1;
        check("reset outputs", {busy, done, error, mem_read, mem_write, count, mem_address, mem_write_data}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            rd0  = rd_total;
            wr0  = wr_total;
            bad0 = bad_total;
            run_job(vecs[v].src, vecs[v].dst, vecs[v].len, cyc, seen);
            check($sformatf("v%0d done seen", v), 32'(seen), 1);
            check($sformatf("v%0d latency", v), cyc, vecs[v].exp_cycles);
            check($sformatf("v%0d error", v), 32'(error), 32'(vecs[v].exp_err));
            check($sformatf("v%0d count", v), 32'(count), 32'(vecs[v].exp_count));
            @(negedge clk);
            check($sformatf("v%0d done/busy after", v), {done, busy}, 0);
            check($sformatf("v%0d error held", v), 32'(error), 32'(vecs[v].exp_err));
            check($sformatf("v%0d reads", v), rd_total - rd0, 32'(vecs[v].exp_count));
            check($sformatf("v%0d writes", v), wr_total - wr0, 32'(vecs[v].exp_count));
            check($sformatf("v%0d bus protocol", v), bad_total - bad0, 0);
            if (!vecs[v].exp_err) begin
                for (int i = 0; i < int'(vecs[v].len); i++)
                    exp_mem[vecs[v].dst + 8'(i)] = exp_mem[vecs[v].src + 8'(i)];
            end
            if (vecs[v].has_last)
                check($sformatf("v%0d last byte", v), mem[5'(vecs[v].dst + vecs[v].len - 8'd1)], 32'(vecs[v].exp_last));
            compare_mem($sformatf("v%0d memory image", v));
        end
        check("overlap mem3", mem[3], 2);
        check("overlap mem4", mem[4], 2);

        // Reset during the second WRITE of a len=4 job.
        load_image(1'b1);
        @(negedge clk);
        src_addr = 8'd0;
        dst_addr = 8'd16;
        length   = 8'd4;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("second write active", {mem_write, mem_address}, {1'b1, 8'd17});
        #2 reset = 1'b1;
        #1;
        check("abort outputs", {busy, done, error, mem_read, mem_write, count, mem_address, mem_write_data}, 0);
        @(negedge clk);
        check("abort stays idle", {busy, mem_read, mem_write}, 0);
        reset = 1'b0;
        check("abort mem16", mem[16], 0);
        check("abort mem17", mem[17], 8'hAA);
        exp_mem[16] = 8'h00;
        run_job(8'd0, 8'd16, 8'd4, cyc, seen);
        check("post-reset latency", cyc, 10);
        check("post-reset count", {error, count}, 4);
        for (int i = 0; i < 4; i++) exp_mem[16 + i] = 8'(i);
        @(negedge clk);
        compare_mem("post-reset memory image");

        // Start while busy and start coincident with done are both ignored.
        dones = 0;
        @(negedge clk);
        src_addr = 8'd0;
        dst_addr = 8'd24;
        length   = 8'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (k == 3) begin
                src_addr = 8'd5;
                dst_addr = 8'd26;
                length   = 8'd3;
                start    = 1'b1;
            end else if (k == 6) begin
                check("busy-start done latency", 32'(done), 1);
                src_addr = 8'd5;
                dst_addr = 8'd26;
                length   = 8'd1;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == 7) check("start at done ignored", 32'(busy), 0);
        end
        check("single done pulse", dones, 1);
        check("ignored job count", 32'(count), 2);
        exp_mem[24] = 8'd0;
        exp_mem[25] = 8'd1;
        compare_mem("ignored start memory image");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator that copies a block of bytes inside the 8-bit data memory: reads from `src_addr`, writes to `dst_addr`, `length` bytes, ascending order.
- Drives the data memory's `mem_read`/`mem_write`/`address`/`write_data` interface and consumes its combinational `read_data`.
- Sits beside the CPU datapath; the bus mux selects this block while `busy`=1.

Parameters:
- ADDR_W, 8, address width of memory bus and of src/dst/length.
- DATA_W, 8, data width.
- MEM_SIZE, 32, number of valid memory locations; used for range check.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- src_addr  input  ADDR_W  first source address; latched on accepted start.
- dst_addr  input  ADDR_W  first destination address; latched on accepted start.
- length  input  ADDR_W  byte count; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until DONE completes.
- done  output  1  one-cycle completion pulse.
- error  output  1  range-violation flag, valid with done; held until next accepted start.
- count  output  ADDR_W  bytes written so far in current/last job.
- mem_read  output  1  read strobe to memory.
- mem_write  output  1  write strobe to memory.
- mem_address  output  ADDR_W  memory address.
- mem_write_data  output  DATA_W  memory write data.
- mem_read_data  input  DATA_W  combinational read data; 0 when mem_read=0.

Behaviour:
- Reset (async): state=IDLE; busy, done, error, mem_read, mem_write=0; count, mem_address, mem_write_data, internal index and data register=0. Reset mid-job aborts immediately; bytes already written stay in memory.
- States: IDLE, CHECK, READ, WRITE, DONE.
- IDLE: all strobes 0, mem_address=0. On start=1: latch src/dst/len, clear count and error, go to CHECK. Start while not IDLE is ignored.
- CHECK (1 cycle, no bus activity):
  - len==0 → DONE, error=0.
  - Else, with 9-bit arithmetic, if src+len>MEM_SIZE or dst+len>MEM_SIZE → DONE, error=1, no memory access.
  - Else → READ with idx=0.
- READ: mem_read=1, mem_address=src+idx. At the posedge, capture mem_read_data into the data register, then go to WRITE.
- WRITE: mem_write=1, mem_address=dst+idx, mem_write_data=data register. At the posedge: count=idx+1, idx=idx+1. If idx+1==len go to DONE, else go to READ.
- mem_read and mem_write are never high in the same cycle.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- busy=1 in CHECK/READ/WRITE/DONE.
- Latency: valid job = 2 + 2·len cycles from start to done pulse (CHECK + 2 per byte + DONE). Error or zero-length job: done 2 cycles after start.
- Overlap: strictly ascending copy. When dst>src and the ranges overlap, later reads see already-written bytes (forward propagation). This is defined behaviour, not an error.
- Address arithmetic is ADDR_W wide; the range check guarantees no wrap.
- start asserted in the same cycle as done is ignored (state is not IDLE).

Test Plan:
- After reset (memory image mem[i]=i for i<16), start src=0 dst=20 len=4 → done at cycle 10 after start, error=0, count=4, mem[20..23]=0,1,2,3, mem[0..3] unchanged.
- Start len=0 src=5 dst=6 → done 2 cycles after start, error=0, count=0, mem_read and mem_write never asserted.
- Start src=30 dst=0 len=3 (30+3>32) → done 2 cycles after start, error=1, no strobes, memory unchanged.
- Overlap src=2 dst=3 len=3 on reset image → mem[3..5]=2,2,2. Also check mem_read/mem_write alternate and are never high together.
- Assert reset during the 2nd WRITE of a len=4 job (src=0 dst=16) → all outputs 0 immediately, state IDLE, mem[16]=0 written, mem[17] written or not per edge; a subsequent start runs normally.
- Pulse start again while busy with different arguments → ignored; the original job completes with its own values and only one done pulse.
